// File: rtl/fwvip_wb_responder_pkg.sv
// Shared types for the Wishbone responder: FSM state encoding, wait counter
// type and the byte-lane helper used to derive the word index.
package fwvip_wb_pkg_hdl;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_state_e;

   localparam int WAIT_CNT_WIDTH = 4;
   typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;

   // Number of low address bits that select a byte within one data word.
   function automatic int lane_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/fwvip_wb_responder_if.sv
// Wishbone classic bus between an initiator (master) and the responder (slave).
interface fwvip_wb_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   adr;
   logic [DATA_WIDTH-1:0]   dat_w;
   logic [DATA_WIDTH-1:0]   dat_r;
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] sel;
   logic                    ack;
   logic                    err;

   modport master (
      output adr, dat_w, cyc, stb, we, sel,
      input  dat_r, ack, err
   );

   modport slave (
      input  adr, dat_w, cyc, stb, we, sel,
      output dat_r, ack, err
   );
endinterface

// File: rtl/fwvip_wb_responder_mem.sv
// Single-port word array with per-byte write enables, synchronous write and
// combinational read of the addressed word.
module fwvip_wb_responder_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clock,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [AW-1:0]           addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the array is deliberately never reset, so contents survive a bus
   // reset and the storage maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/fwvip_wb_responder.sv
// Wishbone responder backed by a local memory: latches one request, inserts
// WAIT_STATES cycles, then terminates with a single ack or err pulse.
module fwvip_wb_responder
   import fwvip_wb_pkg_hdl::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input logic                 clock,
   input logic                 reset,
   fwvip_wb_responder_if.slave bus
);
   localparam int LSB    = lane_bits(DATA_WIDTH);
   localparam int IDX_W  = ADDR_WIDTH - LSB;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam logic [63:0] DEPTH_64 = 64'(DEPTH);
   localparam wait_cnt_t WS_LOAD = wait_cnt_t'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   wb_state_e             state_q, state_d;
   wait_cnt_t             cnt_q, cnt_d;
   logic                  ack_q, err_q;
   logic                  we_q, oor_q;
   logic [NBYTES-1:0]     sel_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic [MEM_AW-1:0]     addr_q;

   logic [IDX_W-1:0]      word_idx;
   logic                  oor_now, req, resp_err, mem_wr;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign word_idx = bus.adr[ADDR_WIDTH-1:LSB];
   assign oor_now  = 64'(word_idx) >= DEPTH_64;
   assign req      = (state_q == IDLE) && bus.cyc && bus.stb;
   // With no wait states the range decision comes straight from the bus.
   assign resp_err = (state_q == IDLE) ? oor_now : oor_q;

   // NOTE: every output of this block is given a default before the case, so
   // no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.cyc && bus.stb) begin
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (!bus.cyc)        state_d = IDLE;
            else if (cnt_q == '0) state_d = RESP;
            else                 cnt_d   = cnt_q - 1'b1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers take non-blocking assignments so every flop samples the
   // values from before the edge; the combinational block above uses blocking.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= (state_d == RESP) && !resp_err;
         err_q   <= (state_d == RESP) && resp_err;
      end
   end

   // Request capture is qualified by the FSM, so these need no reset.
   always_ff @(posedge clock) begin
      if (req) begin
         addr_q <= word_idx[MEM_AW-1:0];
         we_q   <= bus.we;
         sel_q  <= bus.sel;
         dat_q  <= bus.dat_w;
         oor_q  <= oor_now;
      end
   end

   // The write lands on the edge that ends RESP unless reset cancels it.
   assign mem_wr = (state_q == RESP) && we_q && !oor_q && !reset;

   fwvip_wb_responder_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (MEM_AW)
   ) u_mem (
      .clock (clock),
      .wr_en (mem_wr),
      .be    (sel_q),
      .addr  (addr_q),
      .wdata (dat_q),
      .rdata (mem_rdata)
   );

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.dat_r = (ack_q && !we_q) ? mem_rdata : '0;
endmodule

// File: doc/fwvip_wb_responder.md
FWVIP_WB_RESPONDER -- requirements
Module: fwvip_wb_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, byte-address width of adr.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data bus width, one of 8/16/32/64.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of DATA_WIDTH-bit memory words.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, range 0..15, extra cycles inserted before each acknowledge.
REQ-005 clock  input  1  single clock; all logic is sampled on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 adr  input  ADDR_WIDTH  byte address from the initiator.
REQ-008 dat_w  input  DATA_WIDTH  write data.
REQ-009 dat_r  output  DATA_WIDTH  read data.
REQ-010 cyc  input  1  bus cycle in progress.
REQ-011 stb  input  1  strobe, request valid.
REQ-012 we  input  1  1 = write, 0 = read.
REQ-013 sel  input  DATA_WIDTH/8  byte lane enables.
REQ-014 ack  output  1  normal termination.
REQ-015 err  output  1  error termination.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
- IDLE: on cyc&&stb, latch adr/we/sel/dat_w; go to WAIT if WAIT_STATES>0 with the counter loaded to WAIT_STATES-1, else go to RESP.
- WAIT: decrement per cycle; go to RESP at 0.
- RESP: drive ack or err for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be: ack/err asserted exactly WAIT_STATES+1 cycles after the edge at which cyc&&stb is first sampled in IDLE.
REQ-018 ack and err SHALL be registered, each a one-cycle pulse, and never asserted together.
REQ-019 After RESP the block SHALL spend at least one cycle in IDLE, so back-to-back requests have a minimum period of WAIT_STATES+2 cycles.
REQ-020 Word index SHALL be adr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; the low address bits SHALL be ignored.
REQ-021 A word index >= DEPTH SHALL produce err instead of ack, with no memory write and dat_r = 0.
REQ-022 A write SHALL update only the byte lanes with sel=1, committed at the clock edge ending the RESP cycle; sel=0 on all lanes SHALL be acked with no change.
REQ-023 On a read, dat_r SHALL hold the addressed word during the ack cycle and be 0 in every other cycle.
REQ-024 If cyc is deasserted while in WAIT, the block SHALL return to IDLE next cycle with no ack/err and no memory write (abort).
REQ-025 In RESP the termination SHALL be issued regardless of the cyc/stb level in that cycle; a held stb in the cycle after ack SHALL be treated as a new request.
REQ-026 Request inputs SHALL be ignored outside IDLE; the latched values SHALL be used.

Reset
REQ-027 While reset=1, the FSM SHALL go to IDLE, the wait counter to 0, and ack=0, err=0, dat_r=0, effective on the next edge.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the transfer with no ack/err and no write.

Structure
REQ-030 The FSM state enum and the WAIT_STATES counter width (4 bits) SHALL live in fwvip_wb_pkg_hdl typedefs.
REQ-031 The memory SHALL be a sub-module fwvip_wb_responder_mem: a single-port, byte-enable, synchronous-write array of DEPTH words.

Verification
REQ-032 WAIT_STATES=0: write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> each ack arrives 1 cycle after the request is sampled; read dat_r=0xDEADBEEF.
REQ-033 WAIT_STATES=3: read 0x04 after writing 0x12345678 -> ack arrives exactly 4 cycles after the request; dat_r=0x12345678 only in the ack cycle.
REQ-034 Start with word 0x20 = 0xFFFFFFFF; write 0x000000AA to 0x20 with sel=0x1 -> readback 0xFFFFFFAA.
REQ-035 DEPTH=256, DATA_WIDTH=32: access adr=0x400 -> err pulses once, ack stays 0, no memory change, dat_r=0.
REQ-036 WAIT_STATES=5: drop cyc 2 cycles into a write to 0x08 -> no ack/err; readback shows the old value.
REQ-037 Assert reset during WAIT of a write to 0x0C -> no ack; previously written data at 0x0C and 0x10 survives; the next request completes normally.
